// File: rtl/mem_access_stage.sv
// RISC-V memory stage: issues aligned LOAD/STORE requests on the data port, extracts load lanes,
// and presents one writeback record per executed instruction. Alignment and bus timeouts are flagged.
module mem_access_stage #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ex_valid_in,
   output logic        ex_ready_out,
   input  logic [3:0]  ex_itype_in,
   input  logic [2:0]  ex_memfunc_in,
   input  logic [4:0]  ex_dst_in,
   input  logic [31:0] ex_data_in,
   input  logic [31:0] ex_addr_in,
   input  logic [31:0] ex_nextpc_in,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic [3:0]  mem_wstrb_out,
   input  logic        mem_gnt_in,
   input  logic        mem_rvalid_in,
   input  logic [31:0] mem_rdata_in,
   output logic        wb_valid_out,
   input  logic        wb_ready_in,
   output logic        wb_we_out,
   output logic [4:0]  wb_dst_out,
   output logic [31:0] wb_data_out,
   output logic [31:0] wb_nextpc_out,
   output logic        misalign_err_out,
   output logic        bus_err_out
);

   localparam logic [3:0] IT_OP     = 4'd0;
   localparam logic [3:0] IT_OPIMM  = 4'd1;
   localparam logic [3:0] IT_LUI    = 4'd2;
   localparam logic [3:0] IT_JAL    = 4'd3;
   localparam logic [3:0] IT_JALR   = 4'd4;
   localparam logic [3:0] IT_AUIPC  = 4'd5;
   localparam logic [3:0] IT_PMUL   = 4'd6;
   localparam logic [3:0] IT_LOAD   = 4'd7;
   localparam logic [3:0] IT_STORE  = 4'd8;

   localparam logic [2:0] MF_LW  = 3'd0;
   localparam logic [2:0] MF_LH  = 3'd1;
   localparam logic [2:0] MF_LHU = 3'd2;
   localparam logic [2:0] MF_LB  = 3'd3;
   localparam logic [2:0] MF_LBU = 3'd4;
   localparam logic [2:0] MF_SW  = 3'd5;
   localparam logic [2:0] MF_SH  = 3'd6;
   localparam logic [2:0] MF_SB  = 3'd7;

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    itype_q, itype_d;
   logic [2:0]    func_q, func_d;
   logic [4:0]    dst_q, dst_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   nextpc_q, nextpc_d;
   // Holds store data until the request retires, then the load result or pass-through value.
   logic [31:0]   res_q, res_d;
   logic          mis_q, mis_d;
   logic          bus_q, bus_d;

   logic          accept;
   logic          ex_is_mem;
   logic          ex_mis;
   logic          is_store_q;
   logic          in_req;
   logic          in_resp;
   logic [31:0]   st_wdata;
   logic [3:0]    st_wstrb;

   function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
      case (f)
         MF_LW, MF_SW:          return a != 2'b00;
         MF_LH, MF_LHU, MF_SH:  return a[0];
         default:               return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] k,
                                            input logic [31:0] rd);
      logic [31:0] w;
      w = rd >> {k, 3'b000};
      case (f)
         MF_LB:   return {{24{w[7]}}, w[7:0]};
         MF_LBU:  return {24'h0, w[7:0]};
         MF_LH:   return {{16{w[15]}}, w[15:0]};
         MF_LHU:  return {16'h0, w[15:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [3:0] it);
      case (it)
         IT_OP, IT_OPIMM, IT_LUI, IT_JAL, IT_JALR, IT_AUIPC, IT_PMUL, IT_LOAD: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign ex_is_mem  = (ex_itype_in == IT_LOAD) || (ex_itype_in == IT_STORE);
   assign ex_mis     = ex_is_mem && misaligned(ex_memfunc_in, ex_addr_in[1:0]);
   assign is_store_q = (itype_q == IT_STORE);
   assign in_req     = (state_q == S_REQ);
   assign in_resp    = (state_q == S_RESP);

   always_comb begin
      st_wdata = res_q;
      st_wstrb = 4'b1111;
      case (func_q)
         MF_SB: begin
            st_wdata = {4{res_q[7:0]}};
            st_wstrb = 4'b0001 << addr_q[1:0];
         end
         MF_SH: begin
            st_wdata = {2{res_q[15:0]}};
            st_wstrb = 4'b0011 << addr_q[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      itype_d  = itype_q;
      func_d   = func_q;
      dst_d    = dst_q;
      addr_d   = addr_q;
      nextpc_d = nextpc_q;
      res_d    = res_q;
      mis_d    = mis_q;
      bus_d    = bus_q;

      ex_ready_out = (state_q == S_IDLE) || (in_resp && wb_ready_in);
      accept       = ex_valid_in && ex_ready_out;

      case (state_q)
         S_REQ: begin
            if (mem_gnt_in) begin
               state_d = is_store_q ? S_RESP : S_WAIT_R;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               bus_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_R: begin
            if (mem_rvalid_in) begin
               res_d   = load_ext(func_q, addr_q[1:0], mem_rdata_in);
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               bus_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (wb_ready_in) state_d = S_IDLE;
         end
         default: ;
      endcase

      // A fresh record overrides the RESP->IDLE drain so back-to-back ops run at full rate.
      if (accept) begin
         itype_d  = ex_itype_in;
         func_d   = ex_memfunc_in;
         dst_d    = ex_dst_in;
         addr_d   = ex_addr_in;
         nextpc_d = ex_nextpc_in;
         res_d    = ex_data_in;
         mis_d    = ex_mis;
         bus_d    = 1'b0;
         cnt_d    = '0;
         state_d  = (!ex_is_mem || ex_mis) ? S_RESP : S_REQ;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         itype_q  <= '0;
         func_q   <= '0;
         dst_q    <= '0;
         addr_q   <= '0;
         nextpc_q <= '0;
         res_q    <= '0;
         mis_q    <= 1'b0;
         bus_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         itype_q  <= itype_d;
         func_q   <= func_d;
         dst_q    <= dst_d;
         addr_q   <= addr_d;
         nextpc_q <= nextpc_d;
         res_q    <= res_d;
         mis_q    <= mis_d;
         bus_q    <= bus_d;
      end
   end

   assign mem_req_out   = in_req;
   assign mem_we_out    = in_req && is_store_q;
   assign mem_addr_out  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata_out = (in_req && is_store_q) ? st_wdata : 32'h0;
   assign mem_wstrb_out = (in_req && is_store_q) ? st_wstrb : 4'h0;

   assign wb_valid_out     = in_resp;
   assign wb_we_out        = in_resp && writes_rd(itype_q) && (dst_q != 5'd0) && !mis_q && !bus_q;
   assign wb_dst_out       = in_resp ? dst_q : 5'd0;
   assign wb_data_out      = in_resp ? res_q : 32'h0;
   assign wb_nextpc_out    = in_resp ? nextpc_q : 32'h0;
   assign misalign_err_out = in_resp && mis_q;
   assign bus_err_out      = in_resp && bus_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized records checked
// against a byte-lane arithmetic model of the memory stage.
module tb_mem_access_stage;

   localparam logic [3:0] IT_OP = 4'd0, IT_PMUL = 4'd6, IT_LOAD = 4'd7, IT_STORE = 4'd8;
   localparam logic [2:0] MF_LW = 3'd0, MF_LH = 3'd1, MF_LHU = 3'd2, MF_LB = 3'd3,
                          MF_LBU = 3'd4, MF_SW = 3'd5, MF_SH = 3'd6, MF_SB = 3'd7;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        ex_valid_in, ex_ready_out;
   logic [3:0]  ex_itype_in;
   logic [2:0]  ex_memfunc_in;
   logic [4:0]  ex_dst_in;
   logic [31:0] ex_data_in, ex_addr_in, ex_nextpc_in;
   logic        mem_req_out, mem_we_out;
   logic [31:0] mem_addr_out, mem_wdata_out;
   logic [3:0]  mem_wstrb_out;
   logic        mem_gnt_in, mem_rvalid_in;
   logic [31:0] mem_rdata_in;
   logic        wb_valid_out, wb_ready_in, wb_we_out;
   logic [4:0]  wb_dst_out;
   logic [31:0] wb_data_out, wb_nextpc_out;
   logic        misalign_err_out, bus_err_out;

   int n_chk = 0;
   int n_err = 0;

   mem_access_stage #(.TIMEOUT_CYC(256)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out),
      .ex_itype_in(ex_itype_in), .ex_memfunc_in(ex_memfunc_in), .ex_dst_in(ex_dst_in),
      .ex_data_in(ex_data_in), .ex_addr_in(ex_addr_in), .ex_nextpc_in(ex_nextpc_in),
      .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_wdata_out(mem_wdata_out), .mem_wstrb_out(mem_wstrb_out),
      .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
      .wb_valid_out(wb_valid_out), .wb_ready_in(wb_ready_in), .wb_we_out(wb_we_out),
      .wb_dst_out(wb_dst_out), .wb_data_out(wb_data_out), .wb_nextpc_out(wb_nextpc_out),
      .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f);
      if (f == MF_LW || f == MF_SW) return 4;
      if (f == MF_LH || f == MF_LHU || f == MF_SH) return 2;
      return 1;
   endfunction

   function automatic logic writes_rd(input logic [3:0] it);
      return (it <= IT_PMUL) || (it == IT_LOAD);
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] w;
      int v;
      w = rd >> (8 * int'(a[1:0]));
      case (f)
         MF_LB:  begin v = int'(w & 32'hFF);   if (v > 127)   v -= 256;   return 32'(v); end
         MF_LBU: return w & 32'hFF;
         MF_LH:  begin v = int'(w & 32'hFFFF); if (v > 32767) v -= 65536; return 32'(v); end
         MF_LHU: return w & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
      logic [31:0] r;
      int sz;
      sz = size_of(f);
      r = 32'h0;
      for (int i = 0; i < 4; i++) r |= ((d >> (8 * (i % sz))) & 32'hFF) << (8 * i);
      return r;
   endfunction

   function automatic logic [3:0] exp_wstrb(input logic [2:0] f, input logic [31:0] a);
      logic [3:0] r;
      int k, sz;
      k = int'(a[1:0]);
      sz = size_of(f);
      r = 4'h0;
      for (int i = 0; i < 4; i++) if (i >= k && i < k + sz) r[i] = 1'b1;
      return r;
   endfunction

   // One record end to end: accept, optional memory handshake, then writeback with backpressure.
   task automatic do_rec(input logic [3:0] it, input logic [2:0] f, input logic [4:0] dst,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] pc,
                         input logic [31:0] rd, input int gdel, input int rdel, input int ydel);
      logic mem, ld, mis, done, exp_we;
      int sz;
      mem = (it == IT_LOAD) || (it == IT_STORE);
      ld  = (it == IT_LOAD);
      sz  = size_of(f);
      mis = mem && ((int'(a[1:0]) % sz) != 0);
      exp_we = writes_rd(it) && (dst != 5'd0) && !mis;

      chk1("idle_ready", ex_ready_out, 1'b1);
      ex_valid_in = 1'b1; ex_itype_in = it; ex_memfunc_in = f; ex_dst_in = dst;
      ex_data_in = d; ex_addr_in = a; ex_nextpc_in = pc;
      @(negedge clk_in);
      ex_valid_in = 1'b0;

      if (mem && !mis) begin
         chk32("req_addr", mem_addr_out, a & 32'hFFFF_FFFC);
         chk1("req_we", mem_we_out, !ld);
         if (!ld) begin
            chk32("req_wdata", mem_wdata_out, exp_wdata(f, d));
            chk32("req_wstrb", 32'(mem_wstrb_out), 32'(exp_wstrb(f, a)));
         end
         done = 1'b0;
         for (int i = 0; i < 64 && !done; i++) begin
            chk1("req_hold", mem_req_out, 1'b1);
            if (i == gdel) begin
               // bogus rvalid in the grant cycle must be ignored
               mem_gnt_in = 1'b1; mem_rvalid_in = ld; mem_rdata_in = ~rd; done = 1'b1;
            end
            @(negedge clk_in);
            mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
         end
         chk1("req_drop", mem_req_out, 1'b0);
         if (ld) begin
            for (int i = 0; i < rdel; i++) begin
               chk1("wait_no_wb", wb_valid_out, 1'b0);
               @(negedge clk_in);
            end
            mem_rvalid_in = 1'b1; mem_rdata_in = rd;
            @(negedge clk_in);
            mem_rvalid_in = 1'b0;
         end
      end else begin
         chk1("no_req", mem_req_out, 1'b0);
      end

      for (int i = 0; i <= ydel; i++) begin
         chk1("wb_valid", wb_valid_out, 1'b1);
         chk1("wb_we", wb_we_out, exp_we);
         chk32("wb_dst", 32'(wb_dst_out), 32'(dst));
         chk32("wb_nextpc", wb_nextpc_out, pc);
         chk1("wb_misalign", misalign_err_out, mis);
         chk1("wb_buserr", bus_err_out, 1'b0);
         if (!mem) chk32("wb_data_pass", wb_data_out, d);
         if (ld && !mis) chk32("wb_data_load", wb_data_out, exp_load(f, a, rd));
         wb_ready_in = (i == ydel);
         #1 chk1("resp_ex_ready", ex_ready_out, i == ydel);
         @(negedge clk_in);
      end
      wb_ready_in = 1'b0;
      chk1("wb_drained", wb_valid_out, 1'b0);
   endtask

   initial begin
      logic [31:0] prev_d, rd;
      logic [4:0]  prev_dst;
      logic [3:0]  it;
      logic [2:0]  f;
      int cnt;
      logic done;

      rst_in = 1'b1; ex_valid_in = 1'b0; ex_itype_in = '0; ex_memfunc_in = '0; ex_dst_in = '0;
      ex_data_in = '0; ex_addr_in = '0; ex_nextpc_in = '0; mem_gnt_in = 1'b0;
      mem_rvalid_in = 1'b0; mem_rdata_in = '0; wb_ready_in = 1'b0;
      repeat (2) @(negedge clk_in);
      chk1("rst_wb_valid", wb_valid_out, 1'b0);
      chk1("rst_mem_req", mem_req_out, 1'b0);
      chk32("rst_wb_data", wb_data_out, 32'h0);
      chk1("rst_ex_ready", ex_ready_out, 1'b1);
      rst_in = 1'b0;
      @(negedge clk_in);

      // back-to-back pass-through, fixed then random data
      wb_ready_in = 1'b1; ex_valid_in = 1'b1; ex_itype_in = IT_OP; ex_dst_in = 5'd5;
      ex_data_in = 32'h1234; ex_nextpc_in = 32'h100;
      prev_d = 32'h1234; prev_dst = 5'd5;
      @(negedge clk_in);
      for (int i = 0; i < 10; i++) begin
         chk1("b2b_valid", wb_valid_out, 1'b1);
         chk32("b2b_data", wb_data_out, prev_d);
         chk1("b2b_we", wb_we_out, prev_dst != 5'd0);
         chk1("b2b_no_req", mem_req_out, 1'b0);
         if (i >= 4) begin
            ex_data_in = $urandom; ex_dst_in = 5'($urandom);
         end
         prev_d = ex_data_in; prev_dst = ex_dst_in;
         @(negedge clk_in);
      end
      ex_valid_in = 1'b0;
      chk1("b2b_last", wb_valid_out, 1'b1);
      @(negedge clk_in);
      wb_ready_in = 1'b0;
      chk1("b2b_idle", wb_valid_out, 1'b0);

      // directed lane cases
      do_rec(IT_LOAD, MF_LB, 5'd7, 32'h0, 32'h1003, 32'h200, 32'h80FF_0000, 0, 1, 0);
      do_rec(IT_LOAD, MF_LBU, 5'd7, 32'h0, 32'h1003, 32'h204, 32'h80FF_0000, 1, 0, 0);
      do_rec(IT_STORE, MF_SH, 5'd0, 32'hABCD, 32'h2002, 32'h208, 32'h0, 2, 0, 1);
      do_rec(IT_LOAD, MF_LW, 5'd9, 32'h0, 32'h3001, 32'h20C, 32'h0, 0, 0, 0);
      do_rec(IT_LOAD, MF_LW, 5'd0, 32'h0, 32'h3000, 32'h210, 32'hDEAD_BEEF, 0, 2, 5);
      do_rec(IT_OP, MF_LW, 5'd12, 32'hCAFE_F00D, 32'h3003, 32'h214, 32'h0, 0, 0, 5);
      do_rec(IT_STORE, MF_SB, 5'd3, 32'h5A, 32'h2001, 32'h218, 32'h0, 0, 0, 0);

      // grant never arrives: 256 request cycles then bus error
      ex_valid_in = 1'b1; ex_itype_in = IT_LOAD; ex_memfunc_in = MF_LW; ex_dst_in = 5'd4;
      ex_addr_in = 32'h4000; ex_nextpc_in = 32'h300;
      @(negedge clk_in);
      ex_valid_in = 1'b0;
      cnt = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (wb_valid_out) done = 1'b1;
         else begin
            if (mem_req_out) cnt++;
            @(negedge clk_in);
         end
      end
      chk32("tmo_req_cycles", 32'(cnt), 32'd256);
      chk1("tmo_wb_valid", wb_valid_out, 1'b1);
      chk1("tmo_bus_err", bus_err_out, 1'b1);
      chk1("tmo_req_drop", mem_req_out, 1'b0);
      chk1("tmo_we", wb_we_out, 1'b0);
      chk1("tmo_misalign", misalign_err_out, 1'b0);
      wb_ready_in = 1'b1;
      @(negedge clk_in);
      wb_ready_in = 1'b0;
      chk1("tmo_drained", wb_valid_out, 1'b0);

      // reset while waiting for read data: record discarded, late rvalid ignored
      ex_valid_in = 1'b1; ex_addr_in = 32'h5000; ex_dst_in = 5'd6;
      @(negedge clk_in);
      ex_valid_in = 1'b0; mem_gnt_in = 1'b1;
      @(negedge clk_in);
      mem_gnt_in = 1'b0;
      chk1("wr_no_req", mem_req_out, 1'b0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      mem_rvalid_in = 1'b1; mem_rdata_in = $urandom;
      @(negedge clk_in);
      mem_rvalid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("rst_abort_wb", wb_valid_out, 1'b0);
         chk1("rst_abort_ready", ex_ready_out, 1'b1);
         @(negedge clk_in);
      end

      // reset while requesting: request drops next cycle
      ex_valid_in = 1'b1; ex_itype_in = IT_STORE; ex_memfunc_in = MF_SW; ex_addr_in = 32'h6000;
      @(negedge clk_in);
      ex_valid_in = 1'b0;
      chk1("rreq_req", mem_req_out, 1'b1);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      chk1("rreq_drop", mem_req_out, 1'b0);
      mem_gnt_in = 1'b1;
      @(negedge clk_in);
      mem_gnt_in = 1'b0;
      chk1("rreq_no_wb", wb_valid_out, 1'b0);

      // randomized records
      for (int n = 0; n < 60; n++) begin
         it = 4'($urandom_range(0, 11));
         if (it == IT_LOAD) f = 3'($urandom_range(0, 4));
         else if (it == IT_STORE) f = 3'($urandom_range(5, 7));
         else f = 3'($urandom);
         rd = $urandom;
         do_rec(it, f, 5'($urandom), $urandom, $urandom, $urandom, rd,
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
